// File: rtl/guess_game_ctrl_pkg.sv
// Shared definitions for the number-guess sequencer: FSM state codes, comparator
// verdict codes and default widths.
package guess_game_ctrl_pkg;

  localparam int DW_DEF   = 17;
  localparam int CW_DEF   = 4;
  localparam int SYNC_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_WAIT  = 3'd2,
    ST_JUDGE = 3'd3,
    ST_WIN   = 3'd4,
    ST_LOSE  = 3'd5
  } state_t;

  localparam logic [1:0] CMP_EQ   = 2'b00;
  localparam logic [1:0] CMP_GT   = 2'b01;
  localparam logic [1:0] CMP_LT   = 2'b10;
  localparam logic [1:0] CMP_NONE = 2'b11;

endpackage

// File: rtl/guess_game_ctrl_btn_sync_edge.sv
// Push-button conditioner: SYNC-flop synchroniser followed by a release detector
// that emits a one-cycle pulse once a press held for at least SYNC cycles ends.
module btn_sync_edge #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam int HW = $clog2(SYNC + 1);

  logic [SYNC-1:0] sync_q;
  logic            prev;
  logic [HW-1:0]   held;
  logic            cur;

  assign cur = sync_q[SYNC-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev   <= 1'b0;
      held   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], btn};
      prev   <= cur;
      // press length saturates at SYNC; shorter presses are treated as glitches
      if (!cur)
        held <= '0;
      else if (held != HW'(SYNC))
        held <= held + HW'(1);
    end
  end

  assign pulse = prev & ~cur & (held == HW'(SYNC));

endmodule

// File: rtl/guess_game_ctrl.sv
// Number-guess sequencer: latches secret N and guess M, waits for the external
// comparator, records its verdict and counts attempts against the limit.
module guess_game_ctrl
  import guess_game_ctrl_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int CW   = CW_DEF,
  parameter int SYNC = SYNC_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          submit_n,
  input  logic          submit_m,
  input  logic [DW-1:0] data_buffer,
  input  logic [CW-1:0] times_in,
  input  logic [1:0]    cmp_out,
  output logic [DW-1:0] n_value,
  output logic [DW-1:0] m_value,
  output logic [1:0]    verdict,
  output logic [CW-1:0] attempts,
  output logic [2:0]    state_o,
  output logic          win,
  output logic          lose
);

  state_t        state;
  logic [CW-1:0] limit;
  logic          ev_n;
  logic          ev_m;
  logic          seed;
  logic [CW-1:0] att_next;
  logic          lim_hit;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  btn_sync_edge #(.SYNC(SYNC)) u_sync_n (
    .clk   (clk),
    .reset (reset),
    .btn   (submit_n),
    .pulse (ev_n)
  );

  btn_sync_edge #(.SYNC(SYNC)) u_sync_m (
    .clk   (clk),
    .reset (reset),
    .btn   (submit_m),
    .pulse (ev_m)
  );

  // a new secret may be loaded from any resting state; it beats a same-cycle guess
  assign seed     = ev_n && (state == ST_IDLE || state == ST_ARMED ||
                             state == ST_WIN  || state == ST_LOSE);
  assign att_next = sat_inc(attempts);
  assign lim_hit  = (limit != '0) && (att_next >= limit);
  assign state_o  = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      n_value  <= '0;
      m_value  <= '0;
      limit    <= '0;
      verdict  <= CMP_NONE;
      attempts <= '0;
      win      <= 1'b0;
      lose     <= 1'b0;
    end else if (seed) begin
      n_value  <= data_buffer;
      limit    <= times_in;
      attempts <= '0;
      verdict  <= CMP_NONE;
      win      <= 1'b0;
      lose     <= 1'b0;
      state    <= ST_ARMED;
    end else begin
      case (state)
        ST_IDLE, ST_WIN, ST_LOSE: ;
        ST_ARMED: begin
          if (ev_m) begin
            m_value <= data_buffer;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: state <= ST_JUDGE;
        ST_JUDGE: begin
          if (cmp_out == CMP_NONE) begin
            state <= ST_ARMED;
          end else begin
            verdict  <= cmp_out;
            attempts <= att_next;
            // equality is honoured even on the final allowed attempt
            if (cmp_out == CMP_EQ) begin
              state <= ST_WIN;
              win   <= 1'b1;
            end else if (lim_hit) begin
              state <= ST_LOSE;
              lose  <= 1'b1;
            end else begin
              state <= ST_ARMED;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          win   <= 1'b0;
          lose  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Scoreboard bench for guess_game_ctrl: a game-level model predicts each settled
// output snapshot; a monitor compares whenever the DUT settles on a new one.
module tb_guess_game_ctrl;

  localparam int DW   = 17;
  localparam int CW   = 4;
  localparam int SYNC = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          submit_n = 1'b0;
  logic          submit_m = 1'b0;
  logic          force_inv = 1'b0;
  logic [DW-1:0] data_buffer = '0;
  logic [CW-1:0] times_in = '0;
  logic [1:0]    cmp_out;
  logic [DW-1:0] n_value;
  logic [DW-1:0] m_value;
  logic [1:0]    verdict;
  logic [CW-1:0] attempts;
  logic [2:0]    state_o;
  logic          win;
  logic          lose;

  always #5 clk = ~clk;

  // external comparator
  assign cmp_out = force_inv ? 2'b11 :
                   (m_value == n_value) ? 2'b00 :
                   (m_value >  n_value) ? 2'b01 : 2'b10;

  guess_game_ctrl #(.DW(DW), .CW(CW), .SYNC(SYNC)) dut (
    .clk         (clk),
    .reset       (reset),
    .submit_n    (submit_n),
    .submit_m    (submit_m),
    .data_buffer (data_buffer),
    .times_in    (times_in),
    .cmp_out     (cmp_out),
    .n_value     (n_value),
    .m_value     (m_value),
    .verdict     (verdict),
    .attempts    (attempts),
    .state_o     (state_o),
    .win         (win),
    .lose        (lose)
  );

  typedef struct packed {
    logic [2:0]    st;
    logic [DW-1:0] n;
    logic [DW-1:0] m;
    logic [1:0]    v;
    logic [CW-1:0] a;
    logic          w;
    logic          l;
  } snap_t;

  localparam snap_t RESET_SNAP = '{st: 3'd0, n: '0, m: '0, v: 2'b11, a: '0, w: 1'b0, l: 1'b0};

  snap_t exp_q[$];
  snap_t last_exp = RESET_SNAP;
  int    checks = 0;
  int    errors = 0;

  // game model: resting state 0 idle, 1 armed, 4 won, 5 lost
  int g_state = 0, g_n = 0, g_m = 0, g_v = 3, g_att = 0, g_limit = 0;

  function automatic snap_t model_snap();
    snap_t s;
    s.st = 3'(g_state);
    s.n  = DW'(g_n);
    s.m  = DW'(g_m);
    s.v  = 2'(g_v);
    s.a  = CW'(g_att);
    s.w  = (g_state == 4);
    s.l  = (g_state == 5);
    return s;
  endfunction

  function automatic snap_t dut_snap();
    return {state_o, n_value, m_value, verdict, attempts, win, lose};
  endfunction

  task automatic publish();
    snap_t s;
    s = model_snap();
    if (s != last_exp) begin
      exp_q.push_back(s);
      last_exp = s;
    end
  endtask

  task automatic model_seed(input int val, input int t);
    g_n = val; g_limit = t; g_att = 0; g_v = 3; g_state = 1;
  endtask

  task automatic model_guess(input int val);
    int c;
    if (g_state != 1) return;
    g_m = val;
    c = force_inv ? 3 : (val == g_n) ? 0 : (val > g_n) ? 1 : 2;
    if (c == 3) return;
    g_v   = c;
    g_att = (g_att < 15) ? g_att + 1 : 15;
    if (c == 0) g_state = 4;
    else if (g_limit != 0 && g_att >= g_limit) g_state = 5;
  endtask

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic press(input bit pn, input bit pm);
    @(negedge clk);
    submit_n = pn;
    submit_m = pm;
    tick(4);
    submit_n = 1'b0;
    submit_m = 1'b0;
  endtask

  task automatic do_n(input int val, input int t, input bit chk_lat);
    int old;
    old = g_state;
    data_buffer = DW'(val);
    times_in    = CW'(t);
    press(1'b1, 1'b0);
    model_seed(val, t);
    publish();
    if (chk_lat) begin
      tick(SYNC);
      check("latency_hold", int'(state_o), old);
      tick(1);
      check("latency_act", int'(state_o), 1);
      tick(5);
    end else begin
      tick(SYNC + 6);
    end
  endtask

  task automatic do_m(input int val);
    data_buffer = DW'(val);
    press(1'b0, 1'b1);
    model_guess(val);
    publish();
    tick(SYNC + 6);
  endtask

  task automatic do_both(input int val, input int t);
    data_buffer = DW'(val);
    times_in    = CW'(t);
    press(1'b1, 1'b1);
    model_seed(val, t);
    publish();
    tick(SYNC + 6);
  endtask

  // monitor: one comparison each time the DUT settles on a new resting snapshot
  initial begin
    snap_t cur, last, e;
    last = RESET_SNAP;
    forever begin
      @(posedge clk);
      #2;
      cur = dut_snap();
      if (cur.st != 3'd2 && cur.st != 3'd3 && cur != last) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change got st=%0d n=%0d m=%0d v=%0d a=%0d w=%0d l=%0d",
                   cur.st, cur.n, cur.m, cur.v, cur.a, cur.w, cur.l);
        end else begin
          e = exp_q.pop_front();
          if (e != cur) begin
            errors++;
            $display("FAIL scoreboard got st=%0d n=%0d m=%0d v=%0d a=%0d w=%0d l=%0d expected st=%0d n=%0d m=%0d v=%0d a=%0d w=%0d l=%0d",
                     cur.st, cur.n, cur.m, cur.v, cur.a, cur.w, cur.l,
                     e.st, e.n, e.m, e.v, e.a, e.w, e.l);
          end
        end
        last = cur;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    tick(3);
    check("rst_state", int'(state_o), 0);
    check("rst_n", int'(n_value), 0);
    check("rst_m", int'(m_value), 0);
    check("rst_verdict", int'(verdict), 3);
    check("rst_attempts", int'(attempts), 0);
    check("rst_win", int'(win), 0);
    check("rst_lose", int'(lose), 0);
    @(negedge clk);
    reset = 1'b1;
    tick(2);

    do_m(5);
    check("idle_m_ignored", int'(state_o), g_state);

    do_n(1234, 3, 1'b1);
    do_m(1000);
    do_m(2000);
    do_m(1234);
    check("win_flag", int'(win), 1);
    check("win_attempts", int'(attempts), 3);
    do_m(999);

    do_n(50, 2, 1'b0);
    do_m(10);
    do_m(90);
    check("lose_flag", int'(lose), 1);
    check("lose_verdict", int'(verdict), 1);
    do_m(50);
    check("lose_held", int'(state_o), 5);

    do_n(7, 0, 1'b0);
    for (int i = 0; i < 20; i++) do_m(100 + i);
    check("unlim_sat", int'(attempts), 15);
    check("unlim_nolose", int'(lose), 0);
    do_m(7);
    check("unlim_win", int'(win), 1);

    do_n(500, 0, 1'b0);
    do_m(600);
    do_both(321, 0);
    check("coll_m", int'(m_value), 600);
    check("coll_n", int'(n_value), 321);
    check("coll_att", int'(attempts), 0);

    do_m(100);
    force_inv = 1'b1;
    do_m(700);
    force_inv = 1'b0;
    check("inv_att", int'(attempts), 1);
    check("inv_verdict", int'(verdict), 2);

    @(negedge clk);
    submit_m = 1'b1;
    @(negedge clk);
    submit_m = 1'b0;
    tick(8);
    check("glitch_state", int'(state_o), g_state);
    check("glitch_m", int'(m_value), g_m);

    data_buffer = DW'(333);
    press(1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state_o == 3'd2) begin
        found = 1'b1;
        break;
      end
    end
    check("wait_reached", int'(found), 1);
    reset = 1'b0;
    g_state = 0; g_n = 0; g_m = 0; g_v = 3; g_att = 0; g_limit = 0;
    publish();
    #1;
    check("midrst_state", int'(state_o), 0);
    check("midrst_m", int'(m_value), 0);
    check("midrst_verdict", int'(verdict), 3);
    check("midrst_attempts", int'(attempts), 0);
    tick(2);
    reset = 1'b1;
    tick(6);
    check("postrst_state", int'(state_o), 0);

    for (int k = 0; k < 40; k++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        do_n(int'($urandom_range(0, 63)), int'($urandom_range(0, 4)), 1'b0);
      end else if (r == 2) begin
        force_inv = 1'b1;
        do_m(int'($urandom_range(0, 63)));
        force_inv = 1'b0;
      end else begin
        do_m(int'($urandom_range(0, 63)));
      end
    end

    tick(10);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
